// File: rtl/shift_reg_ctrl.sv
// Command sequencer for a shift_reg: turns a word stream into WRITEs + UPLOAD, and a read request into READs.
// Latency: command registered the cycle after accept/issue; read data returns 2 cycles after a READ issue.
// Backpressure: wr_ready follows sr_en in WRITE; READ issue gated by rd_ready && sr_en, none after issue.
module shift_reg_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int LENGTH     = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_write,
    input  logic                  start_read,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    input  logic                  rd_ready,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  done,
    input  logic                  sr_en,
    input  logic [DATA_WIDTH-1:0] sr_data_read,
    output logic [1:0]            sr_ctrl_code,
    output logic [DATA_WIDTH-1:0] sr_data_write
);
    localparam int CW = $clog2(LENGTH + 1);
    localparam logic [CW-1:0] LAST = CW'(LENGTH - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WRITE  = 3'd1;
    localparam logic [2:0] S_UPLOAD = 3'd2;
    localparam logic [2:0] S_READ   = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;

    localparam logic [1:0] CODE_UPLOAD = 2'd0;
    localparam logic [1:0] CODE_WRITE  = 2'd2;
    localparam logic [1:0] CODE_READ   = 2'd3;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic          vld_p1;
    logic          vld_p2;
    logic          accept;
    logic          issue;

    assign wr_ready = (state == S_WRITE) && sr_en;
    assign accept   = wr_ready && wr_valid;
    assign issue    = (state == S_READ) && rd_ready && sr_en;
    assign rd_valid = vld_p2;
    assign rd_data  = sr_data_read;
    assign busy     = (state != S_IDLE);
    // Last word out of the pipe is the one whose stage-1 predecessor is empty.
    assign done     = (state == S_UPLOAD) || ((state == S_DRAIN) && vld_p2 && !vld_p1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            cnt           <= '0;
            vld_p1        <= 1'b0;
            vld_p2        <= 1'b0;
            sr_ctrl_code  <= CODE_UPLOAD;
            sr_data_write <= '0;
        end else begin
            sr_ctrl_code <= CODE_UPLOAD;
            vld_p1       <= issue;
            vld_p2       <= vld_p1;
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (start_write)
                        state <= S_WRITE;
                    else if (start_read)
                        state <= S_READ;
                end
                S_WRITE: begin
                    if (accept) begin
                        sr_ctrl_code  <= CODE_WRITE;
                        sr_data_write <= wr_data;
                        if (cnt == LAST) begin
                            cnt   <= '0;
                            state <= S_UPLOAD;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                S_UPLOAD: begin
                    state <= S_IDLE;
                end
                S_READ: begin
                    if (issue) begin
                        sr_ctrl_code <= CODE_READ;
                        if (cnt == LAST) begin
                            cnt   <= '0;
                            state <= S_DRAIN;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (done)
                        state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Bench for shift_reg_ctrl with a behavioural shift register attached to its command side.
module tb_shift_reg_ctrl;
    typedef logic [3:0][7:0] word4_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_write, start_read;
    logic       wr_valid, wr_ready;
    logic [7:0] wr_data;
    logic       rd_ready, rd_valid;
    logic [7:0] rd_data;
    logic       busy, done;
    logic       sr_en;
    logic [7:0] sr_data_read;
    logic [1:0] sr_ctrl_code;
    logic [7:0] sr_data_write;

    logic [7:0] sr_mem [4];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    shift_reg_ctrl #(.DATA_WIDTH(8), .LENGTH(4)) dut (
        .clk(clk), .reset(reset),
        .start_write(start_write), .start_read(start_read),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
        .busy(busy), .done(done),
        .sr_en(sr_en), .sr_data_read(sr_data_read),
        .sr_ctrl_code(sr_ctrl_code), .sr_data_write(sr_data_write)
    );

    // Shift register: WRITE shifts in at the top, READ emits index 0 and rotates.
    always @(posedge clk) begin
        if (sr_ctrl_code == 2'd2) begin
            for (int i = 0; i < 3; i++) sr_mem[i] <= sr_mem[i+1];
            sr_mem[3] <= sr_data_write;
        end else if (sr_ctrl_code == 2'd3) begin
            sr_data_read <= sr_mem[0];
            for (int i = 0; i < 3; i++) sr_mem[i] <= sr_mem[i+1];
            sr_mem[3] <= sr_mem[0];
        end
    end

    task automatic test_reset();
        reset = 1'b1; start_write = 0; start_read = 0; wr_valid = 0; wr_data = 0;
        rd_ready = 0; sr_en = 1;
        #2;
        total++; if (sr_ctrl_code !== 2'd0) begin bad++; $display("FAIL reset_code: got %0d want 0", sr_ctrl_code); end
        total++; if (sr_data_write !== 8'h00) begin bad++; $display("FAIL reset_wdata: got %h want 00", sr_data_write); end
        total++; if ({busy, done, wr_ready, rd_valid} !== 4'b0000) begin bad++; $display("FAIL reset_flags: got %b want 0000", {busy, done, wr_ready, rd_valid}); end
        @(posedge clk); @(posedge clk); #1; reset = 1'b0;
    endtask

    task automatic test_write_burst(input word4_t w, input string tag);
        @(posedge clk); #1; start_write = 1; #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s_idle_busy: got %b want 0", tag, busy); end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1; start_write = 0; wr_valid = 1; wr_data = w[i]; #1;
            total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL %s_wr_ready[%0d]: got %b want 1", tag, i, wr_ready); end
            if (i > 0) begin
                total++;
                if (sr_ctrl_code !== 2'd2 || sr_data_write !== w[i-1]) begin
                    bad++; $display("FAIL %s_wcmd[%0d]: got code %0d data %h want code 2 data %h", tag, i, sr_ctrl_code, sr_data_write, w[i-1]);
                end
            end
        end
        @(posedge clk); #1; wr_valid = 0; #1;
        total++; if (sr_ctrl_code !== 2'd2 || sr_data_write !== w[3] || done !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL %s_upload: got code %0d data %h done %b busy %b want 2 %h 1 1", tag, sr_ctrl_code, sr_data_write, w[3], done, busy);
        end
        @(posedge clk); #2;
        total++; if (sr_ctrl_code !== 2'd0 || done !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL %s_after: got code %0d done %b busy %b want 0 0 0", tag, sr_ctrl_code, done, busy);
        end
        for (int i = 0; i < 4; i++) begin
            total++; if (sr_mem[i] !== w[i]) begin bad++; $display("FAIL %s_contents[%0d]: got %h want %h", tag, i, sr_mem[i], w[i]); end
        end
    endtask

    task automatic test_read_burst(input word4_t w, input string tag);
        logic       exp_v;
        logic [1:0] exp_code;
        @(posedge clk); #1; start_read = 1; rd_ready = 1; #1;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk); #1; start_read = 0; #1;
            exp_v    = (c >= 3 && c <= 6);
            exp_code = (c >= 2 && c <= 5) ? 2'd3 : 2'd0;
            total++; if (sr_ctrl_code !== exp_code) begin bad++; $display("FAIL %s_code[c%0d]: got %0d want %0d", tag, c, sr_ctrl_code, exp_code); end
            total++; if (rd_valid !== exp_v) begin bad++; $display("FAIL %s_valid[c%0d]: got %b want %b", tag, c, rd_valid, exp_v); end
            if (exp_v) begin
                total++; if (rd_data !== w[c-3]) begin bad++; $display("FAIL %s_data[c%0d]: got %h want %h", tag, c, rd_data, w[c-3]); end
            end
            total++; if (done !== (c == 6)) begin bad++; $display("FAIL %s_done[c%0d]: got %b want %b", tag, c, done, (c == 6)); end
            total++; if (busy !== (c <= 6)) begin bad++; $display("FAIL %s_busy[c%0d]: got %b want %b", tag, c, busy, (c <= 6)); end
        end
    endtask

    task automatic test_backpressure(input word4_t w);
        // Issues expected in cycles 1,3,5,7: codes at 2,4,6,8, data at 3,5,7,9.
        logic       exp_v;
        logic [1:0] exp_code;
        int         k = 0;
        @(posedge clk); #1; start_read = 1; rd_ready = 0; #1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1; start_read = 0; rd_ready = (c % 2 == 1); #1;
            exp_code = (c >= 2 && c <= 8 && c % 2 == 0) ? 2'd3 : 2'd0;
            exp_v    = (c >= 3 && c <= 9 && c % 2 == 1);
            total++; if (sr_ctrl_code !== exp_code) begin bad++; $display("FAIL bp_code[c%0d]: got %0d want %0d", c, sr_ctrl_code, exp_code); end
            total++; if (rd_valid !== exp_v) begin bad++; $display("FAIL bp_valid[c%0d]: got %b want %b", c, rd_valid, exp_v); end
            if (exp_v) begin
                total++; if (rd_data !== w[k]) begin bad++; $display("FAIL bp_data[%0d]: got %h want %h", k, rd_data, w[k]); end
                k++;
            end
            total++; if (done !== (c == 9)) begin bad++; $display("FAIL bp_done[c%0d]: got %b want %b", c, done, (c == 9)); end
        end
        rd_ready = 0;
    endtask

    task automatic test_write_stall();
        word4_t     w        = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
        logic [9:1] vld_tab  = 9'b1_0111_1101; // bit c = wr_valid in cycle c
        logic [9:1] en_tab   = 9'b1_1100_0111; // bit c = sr_en in cycle c
        logic       prev_acc = 1'b0;
        logic       acc;
        int         k = 0;
        @(posedge clk); #1; start_write = 1; #1;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk); #1; start_write = 0;
            wr_valid = vld_tab[c]; sr_en = en_tab[c]; wr_data = w[k[1:0]]; #1;
            total++; if (wr_ready !== en_tab[c]) begin bad++; $display("FAIL stall_ready[c%0d]: got %b want %b", c, wr_ready, en_tab[c]); end
            total++; if (sr_ctrl_code !== (prev_acc ? 2'd2 : 2'd0)) begin bad++; $display("FAIL stall_code[c%0d]: got %0d want %0d", c, sr_ctrl_code, prev_acc ? 2 : 0); end
            total++; if (done !== 1'b0) begin bad++; $display("FAIL stall_early_done[c%0d]: got %b want 0", c, done); end
            acc = vld_tab[c] && en_tab[c];
            if (acc) k++;
            prev_acc = acc;
        end
        @(posedge clk); #1; wr_valid = 0; sr_en = 1; #1;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL stall_done: got %b want 1", done); end
        @(posedge clk); #2;
        for (int i = 0; i < 4; i++) begin
            total++; if (sr_mem[i] !== w[i]) begin bad++; $display("FAIL stall_contents[%0d]: got %h want %h", i, sr_mem[i], w[i]); end
        end
    endtask

    task automatic test_arb_reset();
        word4_t w2 = {8'h04, 8'h03, 8'h02, 8'h01};
        @(posedge clk); #1; start_write = 1; start_read = 1; #1;
        @(posedge clk); #1; start_write = 0; wr_valid = 1; wr_data = 8'h5A; #1;
        total++; if (wr_ready !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL arb_write_wins: got ready %b busy %b want 1 1", wr_ready, busy); end
        @(posedge clk); #1; start_read = 0; wr_data = 8'h6B; #1;
        total++; if (sr_ctrl_code !== 2'd2 || sr_data_write !== 8'h5A) begin bad++; $display("FAIL arb_wcmd: got code %0d data %h want 2 5a", sr_ctrl_code, sr_data_write); end
        @(posedge clk); #1; reset = 1; wr_data = 8'h7C; #1;
        total++; if (sr_ctrl_code !== 2'd0 || sr_data_write !== 8'h00) begin bad++; $display("FAIL midreset_cmd: got code %0d data %h want 0 00", sr_ctrl_code, sr_data_write); end
        total++; if ({busy, wr_ready, rd_valid, done} !== 4'b0000) begin bad++; $display("FAIL midreset_flags: got %b want 0000", {busy, wr_ready, rd_valid, done}); end
        @(posedge clk); #1; reset = 0; wr_valid = 0; #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL postreset_busy: got %b want 0", busy); end
        test_write_burst(w2, "rewrite");
        test_read_burst(w2, "reread");
    endtask

    initial begin
        word4_t w1 = {8'h44, 8'h33, 8'h22, 8'h11};
        test_reset();
        test_write_burst(w1, "write");
        test_read_burst(w1, "read1");
        test_read_burst(w1, "read2");
        test_backpressure(w1);
        test_write_stall();
        test_arb_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_reg_ctrl.md
Name: shift_reg_ctrl

Overview:
- Command-side sequencer for a `shift_reg` instance in the systolic array datapath.
- Converts an input word stream into LENGTH serial REG_WRITE commands followed by one REG_UPLOAD.
- Converts a read request into LENGTH REG_READ commands and returns the words as an output stream.
- Sole driver of the shift register's `ctrl_code` and `data_write`; sole consumer of its `data_read` and `en`.

Parameters:
- DATA_WIDTH, 8, word width; must match the attached shift register.
- LENGTH, 4, shift register depth; also the number of words per write or read burst.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start_write  input  1  pulse; begins a write burst when IDLE.
- start_read  input  1  pulse; begins a read burst when IDLE.
- wr_valid  input  1  input word valid.
- wr_data  input  DATA_WIDTH  input word.
- wr_ready  output  1  input word accepted when wr_valid && wr_ready.
- rd_ready  input  1  consumer able to take a word two cycles later; gates READ issue.
- rd_valid  output  1  rd_data valid this cycle.
- rd_data  output  DATA_WIDTH  direct wire from sr_data_read.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse at burst completion.
- sr_en  input  1  shift register `en`; when low, no command is issued.
- sr_data_read  input  DATA_WIDTH  shift register `data_read`.
- sr_ctrl_code  output  2  registered command: 0 UPLOAD, 1 LOAD, 2 WRITE, 3 READ.
- sr_data_write  output  DATA_WIDTH  registered write word.

Behaviour:
- States: IDLE, WRITE, UPLOAD, READ, DRAIN.
- Idle command is UPLOAD (0). It is issued whenever no other command is due, and it leaves shift register contents unchanged. LOAD is never issued.
- Reset (asynchronous, any time, including mid-burst) forces:
  - state IDLE, counter 0, read valid pipe cleared;
  - sr_ctrl_code=0, sr_data_write=0;
  - wr_ready=0, rd_valid=0, busy=0, done=0.
- Start arbitration in IDLE:
  - start_write alone → WRITE.
  - start_read alone → READ.
  - Both high together → WRITE wins; start_read is dropped.
  - Starts while busy are ignored.
- WRITE state:
  - wr_ready = sr_en. It is combinational and only high in this state.
  - On accept in cycle t: at the edge ending t, sr_ctrl_code<=2 and sr_data_write<=wr_data. The shift register samples at the end of t+1.
  - Cycles without an accept register sr_ctrl_code<=0; sr_data_write holds its value.
  - Counter width $clog2(LENGTH+1); it counts accepts.
  - On the LENGTH-th accept → UPLOAD.
- UPLOAD state:
  - Lasts one cycle; registers sr_ctrl_code<=0.
  - done=1 in this cycle, then → IDLE.
- READ state:
  - An issue occurs in cycle t when rd_ready && sr_en. At the edge ending t, sr_ctrl_code<=3 and valid pipe stage 1 is set.
  - sr_data_read updates at the end of t+1.
  - rd_valid (pipe stage 2) is high in cycle t+2 with rd_data = sr_data_read. Fixed issue-to-data latency is 2 cycles; there is no backpressure after issue.
  - A non-issue cycle registers code 0.
  - After the LENGTH-th issue → DRAIN.
- DRAIN state:
  - Issues code 0 until the valid pipe is empty.
  - done=1 in the cycle the last rd_valid is high, then → IDLE.
- Rotation: LENGTH READs fully rotate the shift register, so its contents after a read burst equal its contents before.
- sr_en low: stalls issue in WRITE and READ. The counter holds. Words already in flight still complete.

Test Plan:
- Write burst, LENGTH=4: start_write, then stream 0x11, 0x22, 0x33, 0x44 with wr_valid held high. Required:
  - 4 consecutive WRITE codes, one UPLOAD cycle with done=1;
  - shift register data_out = {0x11, 0x22, 0x33, 0x44} (index 0..3).
- Read burst after the write burst: start_read with rd_ready=1. Required:
  - rd_valid on 4 consecutive cycles, first one 3 cycles after start;
  - rd_data sequence 0x11, 0x22, 0x33, 0x44; done on the 4th;
  - a second read burst returns the identical sequence.
- Backpressure: rd_ready toggled 1,0,1,0,...
  - READ codes only in cycles following rd_ready=1;
  - each rd_valid exactly 2 cycles after its issue; no lost or duplicated word.
- Write stalls: wr_valid gaps plus sr_en forced low for 3 cycles mid-burst.
  - wr_ready=0 while sr_en=0; the counter holds;
  - final contents are still the 4 words in order.
- Arbitration and reset: start_write and start_read asserted together → write burst only. start_read during the burst → ignored. reset asserted after 2 accepted words → immediately:
  - sr_ctrl_code=0, busy=0, wr_ready=0;
  - a new full burst then completes correctly.
